// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write path between two round-robin pixel writers
// and a full-screen clear sweep; every issue is gated by vram_available.
module vram_write_scheduler #(
  parameter int ROW_W = 6,
  parameter int COL_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ROW_W-1:0]  a_row,
  input  logic [COL_W-1:0]  a_col,
  input  logic [DATA_W-1:0] a_px_data,
  input  logic              a_overlay,
  output logic              a_grant,
  input  logic              b_req,
  input  logic [ROW_W-1:0]  b_row,
  input  logic [COL_W-1:0]  b_col,
  input  logic [DATA_W-1:0] b_px_data,
  input  logic              b_overlay,
  output logic              b_grant,
  input  logic              clear_req,
  input  logic              clear_overlay,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              vram_available,
  output logic              out_write,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [DATA_W-1:0] out_px_data,
  output logic              out_image_overlay
);

  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic                    last_b_q, last_b_d;
  logic [ROW_W+COL_W-1:0]  cnt_q, cnt_d;
  logic                    clear_busy_q, clear_busy_d;
  logic                    clear_ovl_q, clear_ovl_d;
  logic                    clear_done_q, clear_done_d;
  logic                    out_write_q, out_write_d;
  logic                    a_grant_q, a_grant_d;
  logic                    b_grant_q, b_grant_d;
  logic [ROW_W-1:0]        out_row_q, out_row_d;
  logic [COL_W-1:0]        out_col_q, out_col_d;
  logic [DATA_W-1:0]       out_px_q, out_px_d;
  logic                    out_ovl_q, out_ovl_d;
  logic                    pick_a;

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    clear_busy_d = clear_busy_q;
    clear_ovl_d  = clear_ovl_q;
    clear_done_d = 1'b0;
    out_write_d  = 1'b0;
    a_grant_d    = 1'b0;
    b_grant_d    = 1'b0;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_px_d     = out_px_q;
    out_ovl_d    = out_ovl_q;
    // A wins a tie only when B was served last
    pick_a       = a_req && (!b_req || last_b_q);

    if (clear_req && !clear_busy_q) begin
      clear_busy_d = 1'b1;
      clear_ovl_d  = clear_overlay;
    end

    case (state_q)
      IDLE: begin
        if (clear_busy_q) begin
          state_d = CLEAR;
        end else if (vram_available && (a_req || b_req)) begin
          out_write_d = 1'b1;
          a_grant_d   = pick_a;
          b_grant_d   = !pick_a;
          out_row_d   = pick_a ? a_row : b_row;
          out_col_d   = pick_a ? a_col : b_col;
          out_px_d    = pick_a ? a_px_data : b_px_data;
          out_ovl_d   = pick_a ? a_overlay : b_overlay;
          last_b_d    = !pick_a;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = IDLE;
      CLEAR: begin
        if (vram_available) begin
          out_write_d = 1'b1;
          out_row_d   = cnt_q[ROW_W+COL_W-1:COL_W];
          out_col_d   = cnt_q[COL_W-1:0];
          out_px_d    = CLEAR_VALUE;
          out_ovl_d   = clear_ovl_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            clear_done_d = 1'b1;
            clear_busy_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      cnt_q        <= '0;
      clear_busy_q <= 1'b0;
      clear_ovl_q  <= 1'b0;
      clear_done_q <= 1'b0;
      out_write_q  <= 1'b0;
      a_grant_q    <= 1'b0;
      b_grant_q    <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_px_q     <= '0;
      out_ovl_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      cnt_q        <= cnt_d;
      clear_busy_q <= clear_busy_d;
      clear_ovl_q  <= clear_ovl_d;
      clear_done_q <= clear_done_d;
      out_write_q  <= out_write_d;
      a_grant_q    <= a_grant_d;
      b_grant_q    <= b_grant_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_px_q     <= out_px_d;
      out_ovl_q    <= out_ovl_d;
    end
  end

  assign a_grant           = a_grant_q;
  assign b_grant           = b_grant_q;
  assign clear_busy        = clear_busy_q;
  assign clear_done        = clear_done_q;
  assign out_write         = out_write_q;
  assign out_row           = out_row_q;
  assign out_col           = out_col_q;
  assign out_px_data       = out_px_q;
  assign out_image_overlay = out_ovl_q;

endmodule
